// File: rtl/board_game_pkg.sv
// Shared encodings, FSM states and the line-scan direction table for the N x N
// K-in-a-row game engine.
package board_game_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;
  localparam logic [1:0] WIN_DRAW      = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_OCCUPIED = 2'b01;
  localparam logic [1:0] ST_RANGE    = 2'b10;
  localparam logic [1:0] ST_TURN     = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_MOVE, S_CHECK, S_DONE} state_e;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } delta_t;

  // Scan order: horizontal, vertical, diagonal, anti-diagonal.
  function automatic delta_t dir_delta(input logic [1:0] d);
    delta_t r;
    case (d)
      2'd0:    r = '{dr: 2'sb00, dc: 2'sb01};
      2'd1:    r = '{dr: 2'sb01, dc: 2'sb00};
      2'd2:    r = '{dr: 2'sb01, dc: 2'sb01};
      default: r = '{dr: 2'sb01, dc: 2'sb11};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/board_line_scanner.sv
// Walks K-1 cells each way along the four lines through the last move, one cell
// per cycle, and reports whether any line holds K marks of the mover.
module board_line_scanner
  import board_game_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_scan_i,
  input  logic [RW-1:0] org_row_i,
  input  logic [RW-1:0] org_col_i,
  input  logic [1:0]    mover_i,
  input  logic [1:0]    cell_i,
  output logic [RW-1:0] scan_row_o,
  output logic [RW-1:0] scan_col_o,
  output logic          scan_done_o,
  output logic          win_o
);

  // Two extra bits keep stepped coordinates signed and clear of wrap-around.
  localparam int CW = RW + 2;
  localparam logic signed [CW-1:0] NS = CW'(N);
  localparam logic [3:0] LAST = 4'(K - 2);
  localparam logic [4:0] KR   = 5'(K);

  logic                 busy_q, half_q, chain_q, win_q;
  logic [1:0]           dir_q, mover_q;
  logic [3:0]           step_q;
  logic [4:0]           run_q, run_n;
  logic signed [CW-1:0] org_r_q, org_c_q, cur_r_q, cur_c_q, s_r, s_c;
  logic                 in_b, hit, last, dir_end;
  delta_t               dlt, dnx, d0;

  function automatic logic signed [CW-1:0] sx(input logic signed [1:0] v);
    return {{(CW-2){v[1]}}, v};
  endfunction

  always_comb begin
    dlt     = dir_delta(dir_q);
    dnx     = dir_delta(dir_q + 2'd1);
    d0      = dir_delta(2'd0);
    s_r     = {2'b00, org_row_i};
    s_c     = {2'b00, org_col_i};
    in_b    = !cur_r_q[CW-1] && (cur_r_q < NS) && !cur_c_q[CW-1] && (cur_c_q < NS);
    hit     = chain_q && in_b && (cell_i == mover_q);
    run_n   = run_q + {4'd0, hit};
    last    = (step_q == LAST);
    dir_end = last && half_q;
  end

  assign scan_row_o  = cur_r_q[RW-1:0];
  assign scan_col_o  = cur_c_q[RW-1:0];
  assign scan_done_o = busy_q && dir_end && (dir_q == 2'd3);
  assign win_o       = win_q || (dir_end && (run_n >= KR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      half_q  <= 1'b0;
      chain_q <= 1'b0;
      win_q   <= 1'b0;
      dir_q   <= '0;
      mover_q <= '0;
      step_q  <= '0;
      run_q   <= '0;
      org_r_q <= '0;
      org_c_q <= '0;
      cur_r_q <= '0;
      cur_c_q <= '0;
    end else if (start_scan_i) begin
      busy_q  <= 1'b1;
      half_q  <= 1'b0;
      chain_q <= 1'b1;
      win_q   <= 1'b0;
      dir_q   <= '0;
      mover_q <= mover_i;
      step_q  <= '0;
      run_q   <= 5'd1;
      org_r_q <= s_r;
      org_c_q <= s_c;
      cur_r_q <= s_r + sx(d0.dr);
      cur_c_q <= s_c + sx(d0.dc);
    end else if (busy_q) begin
      run_q   <= run_n;
      chain_q <= hit;
      if (!last) begin
        step_q <= step_q + 4'd1;
        if (half_q) begin
          cur_r_q <= cur_r_q - sx(dlt.dr);
          cur_c_q <= cur_c_q - sx(dlt.dc);
        end else begin
          cur_r_q <= cur_r_q + sx(dlt.dr);
          cur_c_q <= cur_c_q + sx(dlt.dc);
        end
      end else if (!half_q) begin
        half_q  <= 1'b1;
        step_q  <= '0;
        chain_q <= 1'b1;
        cur_r_q <= org_r_q - sx(dlt.dr);
        cur_c_q <= org_c_q - sx(dlt.dc);
      end else begin
        win_q   <= win_o;
        dir_q   <= dir_q + 2'd1;
        half_q  <= 1'b0;
        step_q  <= '0;
        run_q   <= 5'd1;
        chain_q <= 1'b1;
        cur_r_q <= org_r_q + sx(dnx.dr);
        cur_c_q <= org_c_q + sx(dnx.dc);
        busy_q  <= (dir_q != 2'd3);
      end
    end
  end

endmodule

// File: rtl/board_game_engine.sv
// N x N, K-in-a-row two-side game engine: validates moves over valid/ready,
// reports a status per move and runs a sequential win scan after legal moves.
module board_game_engine
  import board_game_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3,
  localparam int RW = $clog2(N)
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          start_i,
  input  logic [1:0]    first_player_i,
  input  logic          move_valid_i,
  output logic          move_ready_o,
  input  logic [RW-1:0] move_row_i,
  input  logic [RW-1:0] move_col_i,
  input  logic [1:0]    move_who_i,
  output logic          move_ack_o,
  output logic [1:0]    move_status_o,
  output logic [1:0]    turn_o,
  output logic          game_over_o,
  output logic [1:0]    winner_o,
  output logic [7:0]    move_count_o,
  input  logic [RW-1:0] rd_row_i,
  input  logic [RW-1:0] rd_col_i,
  output logic [1:0]    rd_cell_o
);

  state_e                   state_q, state_d;
  logic [N-1:0][N-1:0][1:0] board_q;
  logic [1:0]               turn_q, turn_d, winner_q, winner_d, status_q, status_d;
  logic [7:0]               count_q, count_d;
  logic                     ack_q, ack_d, clr, wr_en, start_scan, hs, in_range;
  logic                     scan_done, scan_win;
  logic [RW-1:0]            scan_row, scan_col;

  function automatic logic [1:0] cell_at(input logic [N-1:0][N-1:0][1:0] b,
                                         input logic [RW-1:0] r, input logic [RW-1:0] c);
    if ((32'(r) < N) && (32'(c) < N)) return b[r][c];
    return CELL_EMPTY;
  endfunction

  board_line_scanner #(.N(N), .K(K), .RW(RW)) u_scan (
    .clk          (clock_i),
    .rst_n        (reset_ni),
    .start_scan_i (start_scan),
    .org_row_i    (move_row_i),
    .org_col_i    (move_col_i),
    .mover_i      (move_who_i),
    .cell_i       (cell_at(board_q, scan_row, scan_col)),
    .scan_row_o   (scan_row),
    .scan_col_o   (scan_col),
    .scan_done_o  (scan_done),
    .win_o        (scan_win)
  );

  assign move_ready_o  = (state_q == S_WAIT_MOVE);
  assign game_over_o   = (state_q == S_DONE);
  assign move_ack_o    = ack_q;
  assign move_status_o = status_q;
  assign turn_o        = turn_q;
  assign winner_o      = winner_q;
  assign move_count_o  = count_q;
  assign rd_cell_o     = cell_at(board_q, rd_row_i, rd_col_i);

  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    status_d   = status_q;
    count_d    = count_q;
    ack_d      = 1'b0;
    clr        = 1'b0;
    wr_en      = 1'b0;
    start_scan = 1'b0;
    hs         = move_valid_i && move_ready_o;
    in_range   = (32'(move_row_i) < N) && (32'(move_col_i) < N);
    // A start pulse wins over everything, including a same-cycle handshake.
    if (start_i) begin
      clr      = 1'b1;
      count_d  = '0;
      winner_d = CELL_EMPTY;
      turn_d   = (first_player_i == CELL_COMPUTER) ? CELL_COMPUTER : CELL_PLAYER;
      state_d  = S_WAIT_MOVE;
    end else begin
      case (state_q)
        S_WAIT_MOVE: if (hs) begin
          ack_d = 1'b1;
          if (!in_range)                     status_d = ST_RANGE;
          else if (move_who_i != turn_q)     status_d = ST_TURN;
          else if (cell_at(board_q, move_row_i, move_col_i) != CELL_EMPTY)
                                             status_d = ST_OCCUPIED;
          else begin
            status_d   = ST_OK;
            wr_en      = 1'b1;
            start_scan = 1'b1;
            count_d    = count_q + 8'd1;
            state_d    = S_CHECK;
          end
        end
        S_CHECK: if (scan_done) begin
          if (scan_win) begin
            winner_d = turn_q;
            turn_d   = CELL_EMPTY;
            state_d  = S_DONE;
          end else if (count_q == 8'(N * N)) begin
            winner_d = WIN_DRAW;
            turn_d   = CELL_EMPTY;
            state_d  = S_DONE;
          end else begin
            turn_d   = (turn_q == CELL_PLAYER) ? CELL_COMPUTER : CELL_PLAYER;
            state_d  = S_WAIT_MOVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      board_q  <= '0;
      turn_q   <= '0;
      winner_q <= '0;
      status_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      status_q <= status_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      if (clr)        board_q <= '0;
      else if (wr_en) board_q[move_row_i][move_col_i] <= move_who_i;
    end
  end

endmodule

// File: tb/tb_board_game_engine.sv
// Directed-vector bench for board_game_engine: a 3x3/K=3 and a 5x5/K=4 instance,
// expected ack statuses queued at issue time and popped by per-instance monitors.
module tb_board_game_engine;
  import board_game_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_start, a_vld, a_ready, a_ack, a_go;
  logic [1:0] a_fp, a_row, a_col, a_who, a_st, a_turn, a_win, a_rr, a_rc, a_cell;
  logic [7:0] a_cnt;
  logic       b_start, b_vld, b_ready, b_ack, b_go;
  logic [1:0] b_fp, b_who, b_st, b_turn, b_win, b_cell;
  logic [2:0] b_row, b_col, b_rr, b_rc;
  logic [7:0] b_cnt;

  board_game_engine #(.N(3), .K(3)) dut_a (
    .clock_i(clk), .reset_ni(rst_n), .start_i(a_start), .first_player_i(a_fp),
    .move_valid_i(a_vld), .move_ready_o(a_ready), .move_row_i(a_row), .move_col_i(a_col),
    .move_who_i(a_who), .move_ack_o(a_ack), .move_status_o(a_st), .turn_o(a_turn),
    .game_over_o(a_go), .winner_o(a_win), .move_count_o(a_cnt),
    .rd_row_i(a_rr), .rd_col_i(a_rc), .rd_cell_o(a_cell));

  board_game_engine #(.N(5), .K(4)) dut_b (
    .clock_i(clk), .reset_ni(rst_n), .start_i(b_start), .first_player_i(b_fp),
    .move_valid_i(b_vld), .move_ready_o(b_ready), .move_row_i(b_row), .move_col_i(b_col),
    .move_who_i(b_who), .move_ack_o(b_ack), .move_status_o(b_st), .turn_o(b_turn),
    .game_over_o(b_go), .winner_o(b_win), .move_count_o(b_cnt),
    .rd_row_i(b_rr), .rd_col_i(b_rc), .rd_cell_o(b_cell));

  int checks = 0;
  int passes = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  localparam logic [1:0] P = CELL_PLAYER;
  localparam logic [1:0] C = CELL_COMPUTER;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (a_ack === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        $display("FAIL a_unexpected_ack: got ack status %0h expected no ack", a_st);
      end else chk("a_status", {30'd0, a_st}, {30'd0, qa.pop_front()});
    end
    if (b_ack === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected_ack: got ack status %0h expected no ack", b_st);
      end else chk("b_status", {30'd0, b_st}, {30'd0, qb.pop_front()});
    end
  end

  task automatic go(input bit b, input logic [1:0] fp);
    if (!b) begin a_start = 1'b1; a_fp = fp; end
    else    begin b_start = 1'b1; b_fp = fp; end
    @(posedge clk); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Returns in mid cycle T+1 of a handshake at edge T, after the monitor has run.
  task automatic mv(input bit b, input int r, input int c, input logic [1:0] who,
                    input logic [1:0] exp);
    int n = 0;
    if (!b) begin a_row = r[1:0]; a_col = c[1:0]; a_who = who; a_vld = 1'b1; end
    else    begin b_row = r[2:0]; b_col = c[2:0]; b_who = who; b_vld = 1'b1; end
    while (!(b ? b_ready : a_ready) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) begin
      checks++;
      $display("FAIL mv_timeout: got no move_ready for (%0d,%0d) expected ready", r, c);
      a_vld = 1'b0; b_vld = 1'b0;
    end else begin
      if (!b) qa.push_back(exp); else qb.push_back(exp);
      @(posedge clk); #1;
      a_vld = 1'b0; b_vld = 1'b0;
      @(negedge clk); #1;
      chk("ack_seen", b ? qb.size() : qa.size(), 0);
    end
  endtask

  task automatic rda(input int r, input int c, input logic [1:0] exp, input string name);
    a_rr = r[1:0]; a_rc = c[1:0]; #1;
    chk(name, {30'd0, a_cell}, {30'd0, exp});
  endtask

  initial begin
    a_start = 0; a_vld = 0; a_fp = 0; a_row = 0; a_col = 0; a_who = 0; a_rr = 0; a_rc = 0;
    b_start = 0; b_vld = 0; b_fp = 0; b_row = 0; b_col = 0; b_who = 0; b_rr = 0; b_rc = 0;
    #12;
    chk("rst_ready", a_ready, 0);  chk("rst_ack", a_ack, 0);   chk("rst_status", a_st, 0);
    chk("rst_turn", a_turn, 0);    chk("rst_over", a_go, 0);   chk("rst_winner", a_win, 0);
    chk("rst_count", a_cnt, 0);    chk("rst_b_ready", b_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // IDLE ignores move_valid
    a_vld = 1'b1; a_who = P;
    repeat (3) @(posedge clk);
    #1 chk("idle_ready", a_ready, 0);
    a_vld = 1'b0;
    rda(0, 0, CELL_EMPTY, "idle_cell");

    // Row win for the player
    go(0, 2'b00);
    chk("start_turn_default", a_turn, P);
    chk("start_ready", a_ready, 1);
    mv(0, 0, 0, P, ST_OK); mv(0, 1, 1, C, ST_OK); mv(0, 0, 1, P, ST_OK);
    mv(0, 2, 2, C, ST_OK); mv(0, 0, 2, P, ST_OK);
    repeat (15) @(posedge clk);
    #1 chk("row_not_yet_over", a_go, 0);
    @(posedge clk); #1;
    chk("row_over", a_go, 1); chk("row_winner", a_win, P); chk("row_count", a_cnt, 5);
    chk("row_turn", a_turn, 0); chk("row_ready", a_ready, 0);
    rda(0, 2, P, "row_cell02"); rda(1, 1, C, "row_cell11");

    // Rejections
    go(0, P);
    mv(0, 1, 1, P, ST_OK);
    mv(0, 1, 1, C, ST_OCCUPIED);
    mv(0, 0, 0, P, ST_TURN);
    mv(0, 3, 0, C, ST_RANGE);
    mv(0, 3, 0, P, ST_RANGE);
    mv(0, 0, 3, C, ST_RANGE);
    chk("rej_turn", a_turn, C); chk("rej_count", a_cnt, 1); chk("rej_ready", a_ready, 1);

    // Reset asserted mid-CHECK
    mv(0, 0, 0, C, ST_OK);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", a_cnt, 0); chk("mid_rst_turn", a_turn, 0); chk("mid_rst_ready", a_ready, 0);
    rda(1, 1, CELL_EMPTY, "mid_rst_cell");
    @(posedge clk); #1 rst_n = 1'b1;

    // Draw on 3x3
    go(0, P);
    mv(0, 0, 0, P, ST_OK); mv(0, 1, 1, C, ST_OK); mv(0, 0, 2, P, ST_OK);
    mv(0, 0, 1, C, ST_OK); mv(0, 2, 1, P, ST_OK); mv(0, 1, 2, C, ST_OK);
    mv(0, 1, 0, P, ST_OK); mv(0, 2, 0, C, ST_OK); mv(0, 2, 2, P, ST_OK);
    repeat (15) @(posedge clk);
    #1 chk("draw_not_yet", a_go, 0);
    @(posedge clk); #1;
    chk("draw_over", a_go, 1); chk("draw_winner", a_win, WIN_DRAW); chk("draw_count", a_cnt, 9);
    a_vld = 1'b1; a_row = 0; a_col = 0; a_who = C;
    repeat (4) @(posedge clk);
    #1 chk("draw_no_ready", a_ready, 0);
    a_vld = 1'b0;

    // Restart during CHECK with a same-cycle move_valid
    go(0, C);
    mv(0, 1, 1, C, ST_OK);
    a_vld = 1'b1; a_row = 0; a_col = 0; a_who = C;
    a_start = 1'b1; a_fp = P;
    @(posedge clk); #1;
    a_start = 1'b0; a_vld = 1'b0;
    chk("restart_ready", a_ready, 1); chk("restart_turn", a_turn, P); chk("restart_count", a_cnt, 0);
    rda(1, 1, CELL_EMPTY, "restart_cell");
    // start beats a live handshake in WAIT_MOVE
    a_vld = 1'b1; a_row = 2; a_col = 2; a_who = P; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_vld = 1'b0;
    @(negedge clk); #1;
    chk("prio_count", a_cnt, 0);
    rda(2, 2, CELL_EMPTY, "prio_cell");

    // 5x5, K=4 anti-diagonal ending at the edge
    go(1, C);
    mv(1, 0, 3, C, ST_OK); mv(1, 4, 4, P, ST_OK); mv(1, 1, 2, C, ST_OK);
    mv(1, 4, 3, P, ST_OK); mv(1, 2, 1, C, ST_OK);
    repeat (24) @(posedge clk);
    #1 chk("b_partial_no_win", b_go, 0);
    chk("b_partial_turn", b_turn, P);
    mv(1, 4, 1, P, ST_OK); mv(1, 3, 0, C, ST_OK);
    repeat (23) @(posedge clk);
    #1 chk("b_not_yet_over", b_go, 0);
    @(posedge clk); #1;
    chk("b_over", b_go, 1); chk("b_winner", b_win, C); chk("b_count", b_cnt, 7);
    b_rr = 3'd3; b_rc = 3'd0; #1 chk("b_cell30", b_cell, C);
    b_rr = 3'd5; b_rc = 3'd0; #1 chk("b_cell_oob", b_cell, CELL_EMPTY);

    @(negedge clk); #1;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
